stage_seq: RTL and testbench

STAGE_SEQ -- requirements
Module: stage_seq

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/branch_lut.sv | 20 ++
 rtl/stage_seq.sv | 108 ++++++++++
 tb/tb_stage_seq.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sequencer state enum, stage encodings and the
// branch target table contents used by the PC, decoder and stage sequencer.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_COMMIT = 3'd4,
    ST_HALTED = 3'd5
  } state_t;

  localparam logic [1:0] STG_IDLE   = 2'b00;
  localparam logic [1:0] STG_FETCH  = 2'b00;
  localparam logic [1:0] STG_DECODE = 2'b01;
  localparam logic [1:0] STG_EXEC   = 2'b10;
  localparam logic [1:0] STG_COMMIT = 2'b11;

  // Entries are stored sign-extended to 32 bits so they truncate correctly to any PC width.
  function automatic logic [31:0] br_lut_entry(input logic [4:0] idx);
    logic [31:0] v;
    case (idx)
      5'd0:    v = 32'h0000_0008;
      5'd1:    v = 32'hFFFF_FFFC;
      5'd2:    v = 32'h0000_0010;
      5'd3:    v = 32'h0000_0200;
      5'd4:    v = 32'hFFFF_FFF0;
      5'd5:    v = 32'h0000_0100;
      default: v = 32'h0000_0000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/branch_lut.sv
// Combinational branch target table: L-bit index in, D-bit entry out.
// Contents come from cpu_pkg::br_lut_entry.
module branch_lut #(
  parameter int D = 12,
  parameter int L = 5
) (
  input  logic [L-1:0] idx,
  output logic [D-1:0] entry
);
  import cpu_pkg::*;

  logic [D-1:0] w_table [2**L];

  for (genvar gi = 0; gi < 2**L; gi++) begin : g_entry
    assign w_table[gi] = D'(br_lut_entry(5'(gi)));
  end

  assign entry = w_table[idx];

endmodule

// File: rtl/stage_seq.sv
// Four-stage instruction sequencer producing the stage code and next-PC target.
// Optional STAGE_SEQ_STALL_EN adds a stall input that freezes all state.
module stage_seq #(
  parameter int D = 12,
  parameter int L = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [D-1:0] prog_ctr,
  input  logic         br_taken,
  input  logic         br_abs,
  input  logic [L-1:0] br_idx,
  input  logic         halt,
  output logic [1:0]   stage,
  output logic [D-1:0] target,
  output logic         done
`ifdef STAGE_SEQ_STALL_EN
  ,
  input  logic         stall
`endif
);
  import cpu_pkg::*;

  logic w_stall;
`ifdef STAGE_SEQ_STALL_EN
  assign w_stall = stall;
`else
  assign w_stall = 1'b0;
`endif

  state_t       r_state;
  logic [1:0]   r_stage;
  logic [D-1:0] r_target;
  logic         r_done;
  logic         r_halt_latched;

  logic [D-1:0] w_lut_entry;
  logic [D-1:0] w_target_next;

  branch_lut #(.D(D), .L(L)) u_branch_lut (
    .idx   (br_idx),
    .entry (w_lut_entry)
  );

  // Halt outranks any branch; additions wrap at D bits.
  always_comb begin
    w_target_next = prog_ctr + D'(1);
    if (halt)
      w_target_next = prog_ctr;
    else if (br_taken && br_abs)
      w_target_next = w_lut_entry;
    else if (br_taken)
      w_target_next = prog_ctr + w_lut_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_stage        <= STG_IDLE;
      r_target       <= '0;
      r_done         <= 1'b0;
      r_halt_latched <= 1'b0;
    end else if (!w_stall) begin
      case (r_state)
        ST_IDLE, ST_HALTED: begin
          if (start) begin
            r_state <= ST_FETCH;
            r_stage <= STG_FETCH;
            r_done  <= 1'b0;
          end
        end
        ST_FETCH: begin
          r_state <= ST_DECODE;
          r_stage <= STG_DECODE;
        end
        ST_DECODE: begin
          r_state <= ST_EXEC;
          r_stage <= STG_EXEC;
        end
        ST_EXEC: begin
          r_state        <= ST_COMMIT;
          r_stage        <= STG_COMMIT;
          r_target       <= w_target_next;
          r_halt_latched <= halt;
        end
        ST_COMMIT: begin
          r_stage <= STG_FETCH;
          if (r_halt_latched) begin
            r_state <= ST_HALTED;
            r_done  <= 1'b1;
          end else begin
            r_state <= ST_FETCH;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_stage <= STG_IDLE;
        end
      endcase
    end
  end

  assign stage  = r_stage;
  assign target = r_target;
  assign done   = r_done;

endmodule

// File: tb/tb_stage_seq.sv
// Directed self-checking bench for stage_seq (D=12, L=5); stall checks
// are compiled in when STAGE_SEQ_STALL_EN is defined.
module tb_stage_seq;

  localparam int D = 12;
  localparam int L = 5;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [D-1:0] prog_ctr;
  logic         br_taken;
  logic         br_abs;
  logic [L-1:0] br_idx;
  logic         halt;
  logic [1:0]   stage;
  logic [D-1:0] target;
  logic         done;
`ifdef STAGE_SEQ_STALL_EN
  logic         stall;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  stage_seq #(.D(D), .L(L)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .prog_ctr (prog_ctr),
    .br_taken (br_taken),
    .br_abs   (br_abs),
    .br_idx   (br_idx),
    .halt     (halt),
    .stage    (stage),
    .target   (target),
    .done     (done)
`ifdef STAGE_SEQ_STALL_EN
    ,
    .stall    (stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts in FETCH; drives junk outside EXEC, the real decode in EXEC, ends in COMMIT.
  task automatic run_instr(input string tag, input logic [D-1:0] pc, input logic taken,
                           input logic abs_t, input logic [L-1:0] idx, input logic hlt,
                           input logic [D-1:0] exp_tgt);
    prog_ctr = pc;
    tick();
    check({tag, " decode"}, 32'(stage), 32'(2'b01));
    halt = 1'b1; br_taken = 1'b1; br_abs = ~abs_t; br_idx = idx ^ 5'd6; start = 1'b1;
    tick();
    check({tag, " exec"}, 32'(stage), 32'(2'b10));
    halt = hlt; br_taken = taken; br_abs = abs_t; br_idx = idx; start = 1'b0;
    tick();
    check({tag, " commit"}, 32'(stage), 32'(2'b11));
    check({tag, " target"}, 32'(target), 32'(exp_tgt));
    halt = 1'b0; br_taken = 1'b0; br_abs = 1'b0; br_idx = '0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; prog_ctr = '0;
    br_taken = 1'b0; br_abs = 1'b0; br_idx = '0; halt = 1'b0;
`ifdef STAGE_SEQ_STALL_EN
    stall = 1'b0;
`endif
    tick(); tick();
    check("reset stage", 32'(stage), 32'd0);
    check("reset target", 32'(target), 32'd0);
    check("reset done", 32'(done), 32'd0);

    // Straight-line
    reset = 1'b0; prog_ctr = 12'h010; start = 1'b1;
    tick();
    start = 1'b0;
    check("line fetch", 32'(stage), 32'd0);
    run_instr("line", 12'h010, 1'b0, 1'b0, 5'd0, 1'b0, 12'h011);
    tick();
    check("line cyc5 stage", 32'(stage), 32'd0);
    check("line target hold", 32'(target), 32'h011);

    run_instr("abs jump", 12'h100, 1'b1, 1'b1, 5'd3, 1'b0, 12'h200);
    tick();
    run_instr("rel back", 12'h002, 1'b1, 1'b0, 5'd1, 1'b0, 12'hFFE);
    tick();
    run_instr("pc wrap", 12'hFFF, 1'b0, 1'b0, 5'd3, 1'b0, 12'h000);
    tick();
    run_instr("rel fwd", 12'h0F8, 1'b1, 1'b0, 5'd2, 1'b0, 12'h108);
    tick();
    check("not done", 32'(done), 32'd0);

    // Halt with a simultaneous taken branch
    run_instr("halt", 12'h040, 1'b1, 1'b1, 5'd3, 1'b1, 12'h040);
    tick();
    check("halted stage", 32'(stage), 32'd0);
    check("halted done", 32'(done), 32'd1);
    tick();
    check("halted hold stage", 32'(stage), 32'd0);
    check("halted hold done", 32'(done), 32'd1);
    check("halted target", 32'(target), 32'h040);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart done", 32'(done), 32'd0);
    check("restart stage", 32'(stage), 32'd0);
    tick();
    check("restart decode", 32'(stage), 32'd1);

    // Reset during COMMIT
    tick();
    tick();
    check("pre-reset commit", 32'(stage), 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid reset stage", 32'(stage), 32'd0);
    check("mid reset target", 32'(target), 32'd0);
    check("mid reset done", 32'(done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("idle hold %0d", i), 32'(stage), 32'd0);
    end

    // Reset outranks start
    reset = 1'b1; start = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0;
    tick();
    check("reset over start", 32'(stage), 32'd0);

`ifdef STAGE_SEQ_STALL_EN
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("stall decode", 32'(stage), 32'd1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall hold %0d", i), 32'(stage), 32'd1);
    end
    stall = 1'b0;
    tick();
    check("stall release exec", 32'(stage), 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
